hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Pipeline stall/flush/forwarding control with data-memory handshake.
//           Optional stall-cycle counter enabled by macro HAZARD_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_RsUsed,
  input  logic        ID_RtUsed,
  input  logic        ID_IsBranch,
  input  logic        ID_FlushReq,
  input  logic [4:0]  EX_Rs,
  input  logic [4:0]  EX_Rt,
  input  logic [4:0]  EX_RtRd,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [4:0]  MEM_RtRd,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_RtRd,
  input  logic        IMem_Ready,
  input  logic        DMem_Ack,
  output logic        DMem_Req,
  output logic        IF_Stall,
  output logic        ID_Stall,
  output logic        EX_Stall,
  output logic        MEM_Stall,
  output logic        WB_Stall,
  output logic        IF_Flush,
  output logic [1:0]  ID_FwdRs,
  output logic [1:0]  ID_FwdRt,
  output logic [1:0]  EX_FwdRs,
  output logic [1:0]  EX_FwdRt,
  output logic [31:0] Perf_StallCycles
);

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_WAIT = 2'd1;
  localparam logic [1:0] D_DONE = 2'd2;

  localparam logic [1:0] c_FWD_RF  = 2'b00;
  localparam logic [1:0] c_FWD_MEM = 2'b01;
  localparam logic [1:0] c_FWD_WB  = 2'b10;

  logic [1:0] r_dState;
  logic [1:0] w_dNext;
  logic       w_memAccess;
  logic       w_memStall;
  logic       w_loadUse;
  logic       w_branchHaz;
  logic       w_idStall;

  function automatic logic [1:0] fwdSel(
    input logic [4:0] src,
    input logic       memWr,
    input logic [4:0] memDst,
    input logic       wbWr,
    input logic [4:0] wbDst
  );
    if (memWr && (memDst != 5'd0) && (memDst == src))
      return c_FWD_MEM;
    else if (wbWr && (wbDst != 5'd0) && (wbDst == src))
      return c_FWD_WB;
    else
      return c_FWD_RF;
  endfunction

  function automatic logic srcHit(
    input logic [4:0] dst,
    input logic [4:0] rs,
    input logic       rsUsed,
    input logic [4:0] rt,
    input logic       rtUsed
  );
    return (dst != 5'd0) && ((rsUsed && (dst == rs)) || (rtUsed && (dst == rt)));
  endfunction

  assign w_memAccess = MEM_MemRead | MEM_MemWrite;

  // D_DONE is a one-cycle release so the finished access is not reissued.
  always_comb begin
    w_dNext = r_dState;
    case (r_dState)
      D_IDLE:  if (w_memAccess) w_dNext = D_WAIT;
      D_WAIT:  if (DMem_Ack)    w_dNext = D_DONE;
      D_DONE:  w_dNext = D_IDLE;
      default: w_dNext = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_dState <= D_IDLE;
    else
      r_dState <= w_dNext;
  end

  assign w_memStall  = (r_dState == D_WAIT) || ((r_dState == D_IDLE) && w_memAccess);
  assign w_loadUse   = EX_MemRead && srcHit(EX_RtRd, ID_Rs, ID_RsUsed, ID_Rt, ID_RtUsed);
  assign w_branchHaz = ID_IsBranch &&
                       ((EX_RegWrite && srcHit(EX_RtRd, ID_Rs, ID_RsUsed, ID_Rt, ID_RtUsed)) ||
                        (MEM_MemRead && srcHit(MEM_RtRd, ID_Rs, ID_RsUsed, ID_Rt, ID_RtUsed)));
  assign w_idStall   = w_memStall | w_loadUse | w_branchHaz;

  // Every control output is forced quiet while reset is held.
  assign DMem_Req  = rst & (r_dState == D_IDLE) & w_memAccess;
  assign MEM_Stall = rst & w_memStall;
  assign EX_Stall  = rst & w_memStall;
  assign WB_Stall  = 1'b0;
  assign ID_Stall  = rst & w_idStall;
  assign IF_Stall  = rst & (w_idStall | ~IMem_Ready);
  assign IF_Flush  = rst & ID_FlushReq & ~w_idStall;

  assign EX_FwdRs = rst ? fwdSel(EX_Rs, MEM_RegWrite, MEM_RtRd, WB_RegWrite, WB_RtRd) : c_FWD_RF;
  assign EX_FwdRt = rst ? fwdSel(EX_Rt, MEM_RegWrite, MEM_RtRd, WB_RegWrite, WB_RtRd) : c_FWD_RF;
  assign ID_FwdRs = rst ? fwdSel(ID_Rs, MEM_RegWrite, MEM_RtRd, WB_RegWrite, WB_RtRd) : c_FWD_RF;
  assign ID_FwdRt = rst ? fwdSel(ID_Rt, MEM_RegWrite, MEM_RtRd, WB_RegWrite, WB_RtRd) : c_FWD_RF;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stallCycles;

  always_ff @(posedge clk) begin
    if (!rst)
      r_stallCycles <= 32'd0;
    else if (w_idStall && (r_stallCycles != 32'hFFFF_FFFF))
      r_stallCycles <= r_stallCycles + 32'd1;
  end

  assign Perf_StallCycles = rst ? r_stallCycles : 32'd0;
`else
  assign Perf_StallCycles = 32'd0;
`endif

endmodule
`default_nettype wire
